// File: rtl/obstacle_distance_filter.sv
// -----------------------------------------------------------------------------
// obstacle_distance_filter
//   Cleans up raw ultrasonic distance readings and turns them into drive
//   requests. Implausible readings (0 or above MAX_VALID_CM) are rejected.
//   Valid readings are smoothed by a 2^AVG_LOG2-deep moving average. The
//   average is classified by a hysteretic CLEAR/WARN/STOP/FAULT machine.
//   Too many consecutive bad readings, or no valid reading for
//   TIMEOUT_CYCLES, forces FAULT.
//
// Ports
//   clk_125mhz        : system clock
//   reset             : asynchronous active-low reset
//   distance_cm       : raw distance reading (cm)
//   measurement_ready : new-reading strobe (pulse or held level)
//   filtered_cm       : moving-average distance (cm)
//   filtered_valid    : one-cycle pulse when filtered_cm updates
//   obstacle_state    : 00 CLEAR, 01 WARN, 10 STOP, 11 FAULT
//   slow_request      : high in WARN
//   stop_request      : high in STOP or FAULT
//   sensor_fault      : high in FAULT
//
// Timing: the registered rising edge of measurement_ready marks cycle k.
// The window, sum and counters update at the end of cycle k. filtered_cm,
// filtered_valid and the classified state all appear together in cycle k+2.
// AVG_LOG2 must be at least 1.
// -----------------------------------------------------------------------------
module obstacle_distance_filter #(
  parameter int AVG_LOG2       = 2,
  parameter int MAX_VALID_CM   = 400,
  parameter int WARN_CM        = 50,
  parameter int STOP_CM        = 20,
  parameter int HYST_CM        = 5,
  parameter int MAX_INVALID    = 3,
  parameter int TIMEOUT_CYCLES = 12500000
) (
  input  logic        clk_125mhz,
  input  logic        reset,
  input  logic [15:0] distance_cm,
  input  logic        measurement_ready,
  output logic [15:0] filtered_cm,
  output logic        filtered_valid,
  output logic [1:0]  obstacle_state,
  output logic        slow_request,
  output logic        stop_request,
  output logic        sensor_fault
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int IW = $clog2(MAX_INVALID + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] INV_MAX     = IW'(MAX_INVALID);
  localparam logic [15:0]   MAX_V       = 16'(MAX_VALID_CM);
  localparam logic [15:0]   STOP_ENTER  = 16'(STOP_CM);
  localparam logic [15:0]   WARN_ENTER  = 16'(WARN_CM);
  localparam logic [15:0]   STOP_LEAVE  = 16'(STOP_CM + HYST_CM);
  localparam logic [15:0]   WARN_LEAVE  = 16'(WARN_CM + HYST_CM);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_WARN  = 2'b01,
    ST_STOP  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  // Registers
  logic                      rdy_q, rdy_dly_q;
  logic [N-1:0][15:0]        win_q, win_d;
  logic [SW-1:0]             sum_q, sum_d;
  logic [AVG_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
  logic                      primed_q, primed_d;
  logic [IW-1:0]             inv_cnt_q, inv_cnt_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      eval_q, eval_d;
  logic [15:0]               filt_q, filt_d;
  logic                      fvalid_q, fvalid_d;
  state_e                    state_q, state_d;
  logic                      slow_q, stop_q, fault_q;

  // Combinational helpers
  logic        edge_s;
  logic        in_range_s;
  logic        valid_edge_s;
  logic        invalid_edge_s;
  logic        fault_evt_s;
  logic [15:0] avg_s;

  assign edge_s         = rdy_q & ~rdy_dly_q;
  assign in_range_s     = (distance_cm != 16'd0) && (distance_cm <= MAX_V);
  assign valid_edge_s   = edge_s & in_range_s;
  assign invalid_edge_s = edge_s & ~in_range_s;
  assign avg_s          = 16'(sum_q >> AVG_LOG2);

  // Fault sources: enough consecutive rejects, or the timeout saturating
  // without a valid sample clearing it this cycle.
  assign fault_evt_s = (invalid_edge_s && (inv_cnt_d == INV_MAX)) ||
                       (!valid_edge_s && (tmo_q == TMO_MAX));

  // Window, running sum, reject counter and timeout counter next-state.
  always_comb begin
    win_d     = win_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    inv_cnt_d = inv_cnt_q;
    tmo_d     = tmo_q;
    eval_d    = 1'b0;
    if (valid_edge_s) begin
      eval_d    = 1'b1;
      inv_cnt_d = '0;
      tmo_d     = '0;
      if (!primed_q) begin
        // First sample after reset/fault fills the whole window so the
        // average is immediately meaningful.
        for (int i = 0; i < N; i++) begin
          win_d[i] = distance_cm;
        end
        sum_d    = SW'(distance_cm) << AVG_LOG2;
        wr_ptr_d = '0;
      end else begin
        win_d[wr_ptr_q] = distance_cm;
        sum_d           = sum_q - SW'(win_q[wr_ptr_q]) + SW'(distance_cm);
        wr_ptr_d        = wr_ptr_q + AVG_LOG2'(1);
      end
    end else begin
      if (invalid_edge_s && (inv_cnt_q != INV_MAX)) begin
        inv_cnt_d = inv_cnt_q + IW'(1);
      end else begin
        inv_cnt_d = inv_cnt_q;
      end
      if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + TW'(1);
      end else begin
        tmo_d = tmo_q;
      end
    end
  end

  // Primed flag: dropped by any fault so the next valid sample re-primes.
  always_comb begin
    primed_d = primed_q;
    if (fault_evt_s) begin
      primed_d = 1'b0;
    end else if (valid_edge_s) begin
      primed_d = 1'b1;
    end else begin
      primed_d = primed_q;
    end
  end

  // Filter output stage, one cycle after the window update.
  always_comb begin
    filt_d   = filt_q;
    fvalid_d = 1'b0;
    if (eval_q) begin
      filt_d   = avg_s;
      fvalid_d = 1'b1;
    end else begin
      filt_d   = filt_q;
      fvalid_d = 1'b0;
    end
  end

  // Classification FSM; evaluates the average being published this cycle
  // so the state lands together with filtered_valid. Faults win.
  always_comb begin
    state_d = state_q;
    if (fault_evt_s) begin
      state_d = ST_FAULT;
    end else if (eval_q) begin
      case (state_q)
        ST_CLEAR: begin
          if (avg_s < STOP_ENTER)      state_d = ST_STOP;
          else if (avg_s < WARN_ENTER) state_d = ST_WARN;
          else                         state_d = ST_CLEAR;
        end
        ST_WARN: begin
          if (avg_s < STOP_ENTER)       state_d = ST_STOP;
          else if (avg_s >= WARN_LEAVE) state_d = ST_CLEAR;
          else                          state_d = ST_WARN;
        end
        ST_STOP: begin
          if (avg_s >= WARN_LEAVE)      state_d = ST_CLEAR;
          else if (avg_s >= STOP_LEAVE) state_d = ST_WARN;
          else                          state_d = ST_STOP;
        end
        ST_FAULT: begin
          if (avg_s < STOP_ENTER)      state_d = ST_STOP;
          else if (avg_s < WARN_ENTER) state_d = ST_WARN;
          else                         state_d = ST_CLEAR;
        end
        default: state_d = ST_FAULT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequential state for the whole block.
  always_ff @(posedge clk_125mhz or negedge reset) begin
    if (!reset) begin
      rdy_q     <= 1'b0;
      rdy_dly_q <= 1'b0;
      win_q     <= '0;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      primed_q  <= 1'b0;
      inv_cnt_q <= '0;
      tmo_q     <= '0;
      eval_q    <= 1'b0;
      filt_q    <= 16'd0;
      fvalid_q  <= 1'b0;
      state_q   <= ST_FAULT;
      slow_q    <= 1'b0;
      stop_q    <= 1'b1;
      fault_q   <= 1'b1;
    end else begin
      rdy_q     <= measurement_ready;
      rdy_dly_q <= rdy_q;
      win_q     <= win_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      primed_q  <= primed_d;
      inv_cnt_q <= inv_cnt_d;
      tmo_q     <= tmo_d;
      eval_q    <= eval_d;
      filt_q    <= filt_d;
      fvalid_q  <= fvalid_d;
      state_q   <= state_d;
      slow_q    <= (state_d == ST_WARN);
      stop_q    <= (state_d == ST_STOP) || (state_d == ST_FAULT);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign filtered_cm    = filt_q;
  assign filtered_valid = fvalid_q;
  assign obstacle_state = state_q;
  assign slow_request   = slow_q;
  assign stop_request   = stop_q;
  assign sensor_fault   = fault_q;

endmodule

// File: doc/obstacle_distance_filter.md
Name: obstacle_distance_filter

Overview:
- Consumes raw ultrasonic readings (distance_cm plus a measurement_ready strobe) from the HC-SR04 interface.
- Rejects implausible samples and smooths valid ones with a 2^AVG_LOG2-sample moving average.
- Classifies the result through a hysteretic CLEAR/WARN/STOP/FAULT state machine.
- Drives slow_request and stop_request into the drive/motor-control path.

Parameters:
AVG_LOG2, 2, log2 of moving-average depth N (N=4)
MAX_VALID_CM, 400, largest accepted reading in cm; 0 is always invalid
WARN_CM, 50, below this distance enter WARN
STOP_CM, 20, below this distance enter STOP
HYST_CM, 5, release margin added to thresholds
MAX_INVALID, 3, consecutive invalid samples that force FAULT
TIMEOUT_CYCLES, 12500000, cycles without a valid sample that force FAULT (100 ms at 125 MHz)

Ports:
clk_125mhz  input  1  system clock; all logic is on this clock
reset  input  1  asynchronous, active-low reset
distance_cm  input  16  raw distance from the sensor interface
measurement_ready  input  1  new-reading strobe; a pulse or a level held for any number of cycles
filtered_cm  output  16  averaged distance
filtered_valid  output  1  one-cycle pulse when filtered_cm updates
obstacle_state  output  2  00 CLEAR, 01 WARN, 10 STOP, 11 FAULT
slow_request  output  1  high in WARN
stop_request  output  1  high in STOP or FAULT
sensor_fault  output  1  high in FAULT

Behaviour:
Reset values:
- filtered_cm=0, filtered_valid=0, state=FAULT, stop_request=1, slow_request=0, sensor_fault=1.
- Window, running sum, invalid count and timeout counter are cleared; the primed flag is cleared.

Sample acceptance:
- measurement_ready is registered once; the rising edge (ready=1, ready_d=0) defines cycle k.
- A level held high counts as one sample.
- distance_cm is captured in cycle k.
- A sample is valid when 1 <= d <= MAX_VALID_CM.

Invalid sample:
- Window is not touched; invalid_cnt increments, saturating.
- When invalid_cnt reaches MAX_INVALID, go to FAULT in cycle k+1.
- No filtered_valid pulse.

Valid sample:
- invalid_cnt and the timeout counter clear in cycle k+1.
- If not primed, every window entry and the sum load the sample (sum = d << AVG_LOG2), and primed is set.
- Otherwise the oldest entry is replaced via the circular write pointer and sum = sum - oldest + d.
- Sum width is 16+AVG_LOG2; it cannot overflow.
- Cycle k+2: filtered_cm = sum >> AVG_LOG2 (truncating), filtered_valid=1 for exactly that cycle, state machine evaluates f = new filtered_cm.

State transitions (evaluated only on the filtered_valid cycle):
- CLEAR: f<STOP_CM -> STOP; else f<WARN_CM -> WARN.
- WARN: f<STOP_CM -> STOP; f>=WARN_CM+HYST_CM -> CLEAR.
- STOP: f>=WARN_CM+HYST_CM -> CLEAR; else f>=STOP_CM+HYST_CM -> WARN.
- FAULT: f<STOP_CM -> STOP; f<WARN_CM -> WARN; else CLEAR.
- Threshold comparisons are strict "<" for entry and ">=" for release. f==STOP_CM therefore does not enter STOP.

Timeout:
- Counter increments every cycle not clearing it and saturates at TIMEOUT_CYCLES-1.
- On reaching TIMEOUT_CYCLES-1, go to FAULT the next cycle.
- A valid-sample clear in the same cycle takes priority over timeout.

Entering FAULT:
- Clears primed, so the next valid sample re-primes the window.
- The invalid/timeout fault path has priority over a filtered_valid evaluation in the same cycle.

Outputs:
- obstacle_state, slow_request, stop_request and sensor_fault are registered decodes of state, updated in the same cycle as the state register.

Asynchronous reset mid-operation:
- Outputs return to reset values immediately; any in-flight sample is discarded (no filtered_valid).

Test Plan:
(Defaults, except TIMEOUT_CYCLES=1000.)
1. Release reset, pulse ready with 100 -> obstacle_state=11 and stop=1 before the pulse; 2 cycles after the edge filtered_cm=100, filtered_valid pulses 1 cycle, state=00, stop=0.
2. Samples 100,100,100,100,20,20,20,20,10 -> filtered 100,100,100,100,80,60,40,20,17. State goes CLEAR until 40 (WARN), stays WARN at 20, STOP at 17, slow_request 1 only in WARN.
3. Hysteresis from STOP with window all 17 -> feed 24s: f stays <25, remains STOP. Feed 25s: f=25 -> WARN. Feed 54s: stays WARN. Feed 55s: f=55 -> CLEAR.
4. From CLEAR, samples 0,500,0 -> no filtered_valid; FAULT (11, stop=1, fault=1) one cycle after the third edge. Then sample 200 -> filtered_cm=200 immediately (re-primed), CLEAR.
5. From CLEAR, no edges for 1000 cycles -> FAULT. Separately, ready held high 50 cycles with 80 -> exactly one filtered_valid.
6. Assert reset one cycle after a valid edge -> no filtered_valid; outputs at reset values while reset is low. After release, first sample re-primes the window.
